// File: rtl/box_edge_ctrl_if.sv
// Binary motion-mask stream carrying frame/line syncs and pixel qualifier.
// master drives the stream, slave (the box controller) consumes it.
interface box_edge_ctrl_if;
  logic mask_vsync;
  logic mask_hsync;
  logic mask_valid;
  logic mask_bit;

  modport master (
    output mask_vsync,
    output mask_hsync,
    output mask_valid,
    output mask_bit
  );

  modport slave (
    input mask_vsync,
    input mask_hsync,
    input mask_valid,
    input mask_bit
  );
endinterface

// File: rtl/box_edge_ctrl.sv
// Motion bounding-box controller: accumulates motion-pixel extents per frame,
// latches box edges at frame start. Ports: clk, rst_n, mask (slave), en,
// box_flag, top/bottom/left/right_edge, box_update.
module box_edge_ctrl #(
  parameter logic [10:0] IMG_W       = 11'd1280,
  parameter logic [10:0] IMG_H       = 11'd720,
  parameter logic [20:0] PIX_THR     = 21'd16,
  parameter logic [3:0]  HOLD_FRAMES = 4'd3
) (
  input  logic          clk,
  input  logic          rst_n,
  box_edge_ctrl_if.slave mask,
  input  logic          en,
  output logic          box_flag,
  output logic [10:0]   top_edge,
  output logic [10:0]   bottom_edge,
  output logic [10:0]   left_edge,
  output logic [10:0]   right_edge,
  output logic          box_update
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic vs_d;
  logic hs_d;
  logic valid_d;
  logic vs_rise;
  logic hs_rise;
  logic line_end;

  logic [10:0] x_cnt;
  logic [10:0] y_cnt;
  logic [10:0] min_x;
  logic [10:0] max_x;
  logic [10:0] min_y;
  logic [10:0] max_y;
  logic [20:0] pix_cnt;
  logic [3:0]  hold_cnt;

  logic acc_en;
  logic latch;
  logic hit;
  logic keep;
  logic drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d    <= 1'b0;
      hs_d    <= 1'b0;
      valid_d <= 1'b0;
    end else begin
      vs_d    <= mask.mask_vsync;
      hs_d    <= mask.mask_hsync;
      valid_d <= mask.mask_valid;
    end
  end

  assign vs_rise  = mask.mask_vsync & ~vs_d;
  assign hs_rise  = mask.mask_hsync & ~hs_d;
  assign line_end = valid_d & ~mask.mask_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= 11'd0;
    end else if (hs_rise) begin
      x_cnt <= 11'd0;
    end else if (mask.mask_valid &&
                 x_cnt != IMG_W - 11'd1) begin
      x_cnt <= x_cnt + 11'd1;
    end
  end

  // Lines are counted on the falling edge of the valid run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_cnt <= 11'd0;
    end else if (vs_rise) begin
      y_cnt <= 11'd0;
    end else if (line_end &&
                 y_cnt != IMG_H - 11'd1) begin
      y_cnt <= y_cnt + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (vs_rise) state_nx = ACCUM;
      ACCUM:   if (vs_rise) state_nx = LATCH;
      LATCH:   state_nx = ACCUM;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    acc_en = 1'b0;
    latch  = 1'b0;
    unique case (state)
      ACCUM: acc_en = mask.mask_valid &
                      mask.mask_bit & ~vs_rise;
      LATCH: latch  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_x   <= 11'h7FF;
      min_y   <= 11'h7FF;
      max_x   <= 11'd0;
      max_y   <= 11'd0;
      pix_cnt <= 21'd0;
    end else if (latch) begin
      min_x   <= 11'h7FF;
      min_y   <= 11'h7FF;
      max_x   <= 11'd0;
      max_y   <= 11'd0;
      pix_cnt <= 21'd0;
    end else if (acc_en) begin
      if (x_cnt < min_x) min_x <= x_cnt;
      if (x_cnt > max_x) max_x <= x_cnt;
      if (y_cnt < min_y) min_y <= y_cnt;
      if (y_cnt > max_y) max_y <= y_cnt;
      if (pix_cnt != '1) pix_cnt <= pix_cnt + 21'd1;
    end
  end

  assign hit  = pix_cnt >= PIX_THR;
  assign keep = ~hit & (hold_cnt != 4'd0);
  assign drop = ~hit & (hold_cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_edge    <= 11'd0;
      bottom_edge <= 11'd0;
      left_edge   <= 11'd0;
      right_edge  <= 11'd0;
      box_update  <= 1'b0;
    end else begin
      box_update <= latch & hit;
      if (latch && hit) begin
        left_edge   <= min_x;
        right_edge  <= max_x;
        top_edge    <= min_y;
        bottom_edge <= max_y;
      end
    end
  end

  // Disable wins over any latch decision; edges keep loading regardless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_flag <= 1'b0;
      hold_cnt <= 4'd0;
    end else if (!en) begin
      box_flag <= 1'b0;
      hold_cnt <= 4'd0;
    end else if (latch) begin
      unique case (1'b1)
        hit: begin
          hold_cnt <= HOLD_FRAMES;
          box_flag <= 1'b1;
        end
        keep: begin
          hold_cnt <= hold_cnt - 4'd1;
          box_flag <= 1'b1;
        end
        drop: box_flag <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
